decay_release_env: RTL and testbench
====================================

# decay_release_env

Post-attack envelope stage for the synth voice path. It takes over from the attack stage once the attack has reached full amplitude (shift 0). It then attenuates RAM samples by an increasing arithmetic right shift down to a sustain level, holds that level while the note gate is high, and releases to silence when the gate drops. It mirrors the attack stage, which drives the shift from large toward zero; this block drives the shift from zero toward silence.

## Interface
- DL, 16, sample width (signed data in/out)
- WL, 8, width of step-period parameter
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  synchronous active-low reset
- data_in  in  DL signed  sample from RAM
- D_R_param  in  WL  step period minus 1; the shift changes every D_R_param+1 cycles
- S_param  in  5  sustain shift level; values above DL are clamped to DL
- EN_MC  in  1  note gate; high = key held
- start  in  1  one-cycle pulse from the attack stage's zero flag
- data_out  out  DL signed  attenuated sample (registered)
- total  out  5  current shift amount (registered)
- hold  out  1  high while in SUSTAIN
- z_flg  out  1  high once release has reached silence

## Operation
- States: IDLE, DECAY, SUSTAIN, RELEASE, DONE.
- Reset (RST_N=0 at an edge): state IDLE, total=DL, data_out=0, hold=0, z_flg=0, step counter=0.
- **IDLE**
  - On start=1 and EN_MC=1, go to DECAY with total=0.
  - Otherwise total stays at DL and data_out=0.
- **DECAY**
  - The step counter counts 0..D_R_param. When it wraps, total increments by 1.
  - When total equals the clamped S_param, go to SUSTAIN.
  - If S_param=0, go to SUSTAIN on the next edge with no increment.
- **SUSTAIN**
  - hold=1 and total is frozen.
  - Stays here while EN_MC=1.
- **RELEASE**
  - Entered from DECAY or SUSTAIN when EN_MC=0 at an edge.
  - total increments by 1 per step period, saturating at DL.
  - When total=DL, go to DONE.
- **DONE**
  - z_flg=1 and data_out=0.
  - Stays here until start=1 with EN_MC=1.
- Retrigger:
  - start=1 with EN_MC=1 in any non-reset state forces DECAY with total=0, z_flg=0, hold=0 and the counter cleared.
  - Retrigger outranks the gate-low transition.
- The step counter is cleared on every state entry.
- D_R_param is sampled live. A change takes effect at the next counter comparison.
- Arithmetic:
  - data_out = data_in >>> total, sign-preserving.
  - When total=DL, data_out=0; it is forced to 0, not sign-filled to -1.
- start with EN_MC=0 is ignored.

## Timing
- data_out has one-cycle latency: data_out(n+1) = f(data_in(n), total(n)).
- start sampled high at edge k gives state DECAY and total=0 visible after edge k.
- Step cadence: consecutive total increments are exactly D_R_param+1 cycles apart. The first increment occurs D_R_param+1 edges after state entry.
- hold asserts on the same edge as the SUSTAIN entry and deasserts on the edge that leaves it.
- z_flg asserts on the same edge where total reaches DL in RELEASE.
- Reset mid-operation: all outputs return to their reset values on that edge. Any in-progress decay or release is discarded.

## Configuration
- ENV_ROUND_EN
  - Defined: round half up before shifting. When 0<total<DL, add 1<<(total-1) to data_in in a DL+1-bit intermediate, shift, then saturate to the DL range.
  - Undefined: plain arithmetic shift, which truncates toward negative infinity.
  - State machine and timing are identical in both builds.

## Test plan
- **Reset:** hold RST_N=0 for 3 cycles with data_in=0x7FFF -> data_out=0, total=16, hold=0, z_flg=0.
- **Decay cadence:** D_R_param=3, S_param=4, data_in=0x4000, pulse start with EN_MC=1.
  - total steps 0→4, one increment every 4 cycles.
  - hold rises when total=4.
  - data_out settles at 0x0400.
- **Release to silence:** from the sustain state above, drop EN_MC.
  - total steps 5..16 at a 4-cycle cadence.
  - z_flg=1 at total=16.
  - data_out=0, including for data_in=0x8000.
- **Retrigger:** pulse start mid-release at total=9 -> next edge total=0, z_flg=0, decay restarts.
- **Boundaries:**
  - S_param=0 -> SUSTAIN one edge after start, data_out=data_in delayed 1 cycle.
  - S_param=31 -> clamped to 16, then silence in SUSTAIN.
  - D_R_param=0 -> a step every cycle.
- **Rounding:** total=2, data_in=-3 (0xFFFD).
  - Without ENV_ROUND_EN: -1.
  - With ENV_ROUND_EN: -1 (−3+2=−1, >>>2 → −1).
  - data_in=0x0006 gives 0x0001 without the macro and 0x0002 with it.

Source files
------------

// File: rtl/decay_release_env.sv
// decay_release_env
//
// Post-attack envelope stage. After the attack stage reports full amplitude
// (start pulse), the sample is attenuated by an arithmetic right shift that
// grows by one every D_R_param+1 cycles until the sustain level is reached.
// That level is held while the note gate is high. When the gate drops, the
// shift keeps growing until the sample is silent.
//
// Ports:
//   CLK        in   clock, all state updates on the rising edge
//   RST_N      in   synchronous active-low reset
//   data_in    in   DL-bit signed sample from RAM
//   D_R_param  in   WL-bit step period minus 1 (sampled live)
//   S_param    in   5-bit sustain shift level, clamped to DL
//   EN_MC      in   note gate, high while the key is held
//   start      in   one-cycle pulse from the attack stage's zero flag
//   data_out   out  DL-bit signed attenuated sample (registered)
//   total      out  5-bit current shift amount (registered)
//   hold       out  high while sustaining
//   z_flg      out  high once release has reached silence
//
// Build option:
//   ENV_ROUND_EN  when defined, round half up before shifting and saturate
//                 the result; otherwise plain truncating arithmetic shift.

module decay_release_env #(
  parameter int DL = 16,
  parameter int WL = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic signed [DL-1:0] data_in,
  input  logic [WL-1:0]        D_R_param,
  input  logic [4:0]           S_param,
  input  logic                 EN_MC,
  input  logic                 start,
  output logic signed [DL-1:0] data_out,
  output logic [4:0]           total,
  output logic                 hold,
  output logic                 z_flg
);

  typedef enum logic [2:0] {IDLE, DECAY, SUSTAIN, RELEASE, DONE} state_t;

  localparam logic [4:0]    TOTAL_MAX = 5'(DL);
  localparam logic [WL-1:0] CNT_ONE   = WL'(1);

  state_t               state, state_nxt;
  logic [WL-1:0]        cnt, cnt_nxt;
  logic [4:0]           total_nxt;
  logic                 hold_nxt, z_nxt;
  logic [4:0]           s_level;
  logic [4:0]           total_inc;
  logic                 step;
  logic                 retrigger;
  logic signed [DL-1:0] shaped;

  assign s_level   = (S_param > TOTAL_MAX) ? TOTAL_MAX : S_param;
  assign total_inc = total + 5'd1;
  // >= rather than == so that lowering D_R_param mid-count still wraps at
  // the next comparison instead of running the counter around its range.
  assign step      = (cnt >= D_R_param);
  assign retrigger = start & EN_MC;

  // Next-state logic. Every state entry clears the step counter.
  always_comb begin
    state_nxt = state;
    total_nxt = total;
    cnt_nxt   = cnt;
    hold_nxt  = hold;
    z_nxt     = z_flg;

    if (retrigger) begin
      // A new note restarts decay from full amplitude in any state.
      state_nxt = DECAY;
      total_nxt = 5'd0;
      cnt_nxt   = '0;
      hold_nxt  = 1'b0;
      z_nxt     = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          total_nxt = TOTAL_MAX;
          cnt_nxt   = '0;
        end
        DECAY: begin
          if (!EN_MC) begin
            state_nxt = RELEASE;
            cnt_nxt   = '0;
          end else if (total >= s_level) begin
            // Only reachable at entry with S_param=0 (or S lowered live).
            state_nxt = SUSTAIN;
            hold_nxt  = 1'b1;
            cnt_nxt   = '0;
          end else if (step) begin
            total_nxt = total_inc;
            cnt_nxt   = '0;
            if (total_inc >= s_level) begin
              state_nxt = SUSTAIN;
              hold_nxt  = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        SUSTAIN: begin
          cnt_nxt = '0;
          if (!EN_MC) begin
            state_nxt = RELEASE;
            hold_nxt  = 1'b0;
          end
        end
        RELEASE: begin
          if (total >= TOTAL_MAX) begin
            state_nxt = DONE;
            total_nxt = TOTAL_MAX;
            z_nxt     = 1'b1;
            cnt_nxt   = '0;
          end else if (step) begin
            total_nxt = total_inc;
            cnt_nxt   = '0;
            if (total_inc == TOTAL_MAX) begin
              state_nxt = DONE;
              z_nxt     = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        DONE: begin
          cnt_nxt = '0;
        end
        default: begin
          state_nxt = IDLE;
          total_nxt = TOTAL_MAX;
          cnt_nxt   = '0;
          hold_nxt  = 1'b0;
          z_nxt     = 1'b0;
        end
      endcase
    end
  end

`ifdef ENV_ROUND_EN
  logic signed [DL:0] rnd_ext, rnd_inc, rnd_sum, rnd_shift;

  // Round half up in a one-bit-wider intermediate, then saturate back.
  always_comb begin
    rnd_ext   = {data_in[DL-1], data_in};
    rnd_inc   = '0;
    rnd_sum   = '0;
    rnd_shift = '0;
    shaped    = '0;
    if (total < TOTAL_MAX) begin
      if (total == 5'd0) begin
        shaped = data_in;
      end else begin
        rnd_inc   = {{DL{1'b0}}, 1'b1} << (total - 5'd1);
        rnd_sum   = rnd_ext + rnd_inc;
        rnd_shift = rnd_sum >>> total;
        if (rnd_shift[DL] != rnd_shift[DL-1])
          shaped = rnd_shift[DL] ? {1'b1, {(DL-1){1'b0}}} : {1'b0, {(DL-1){1'b1}}};
        else
          shaped = rnd_shift[DL-1:0];
      end
    end
  end
`else
  // At full shift the output is forced to zero rather than sign-filled.
  always_comb begin
    shaped = '0;
    if (total < TOTAL_MAX)
      shaped = data_in >>> total;
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      total    <= TOTAL_MAX;
      cnt      <= '0;
      hold     <= 1'b0;
      z_flg    <= 1'b0;
      data_out <= '0;
    end else begin
      state    <= state_nxt;
      total    <= total_nxt;
      cnt      <= cnt_nxt;
      hold     <= hold_nxt;
      z_flg    <= z_nxt;
      data_out <= shaped;
    end
  end

endmodule

// File: tb/tb_decay_release_env.sv
// Testbench for decay_release_env: drives note sequences cycle by cycle and
// compares total/hold/z_flg against a closed-form timeline and data_out
// against a scoreboard of expected shifted samples.
module tb_decay_release_env;

  logic        CLK;
  logic        RST_N;
  logic [15:0] data_in;
  logic [7:0]  D_R_param;
  logic [4:0]  S_param;
  logic        EN_MC;
  logic        start;
  logic [15:0] data_out;
  logic [4:0]  total;
  logic        hold;
  logic        z_flg;

  int tests_run = 0;
  int tests_failed = 0;
  logic [4:0]  model_total;
  logic [15:0] exp_q[$];
  int et;

  decay_release_env #(.DL(16), .WL(8)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .data_in(data_in),
    .D_R_param(D_R_param),
    .S_param(S_param),
    .EN_MC(EN_MC),
    .start(start),
    .data_out(data_out),
    .total(total),
    .hold(hold),
    .z_flg(z_flg)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference shaper in integer arithmetic.
  function automatic logic [15:0] ref_shift(input logic [15:0] din, input int t);
    int v;
    v = int'($signed(din));
    if (t >= 16) return 16'h0000;
`ifdef ENV_ROUND_EN
    if (t > 0) begin
      v = v + (1 << (t - 1));
      v = v >>> t;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      return 16'(v);
    end
`endif
    v = v >>> t;
    return 16'(v);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drives one cycle, queues the expected data_out, then checks after the edge.
  task automatic applyStimulus(input logic [15:0] din, input logic en, input logic st,
                               input int exp_total, input logic exp_hold,
                               input logic exp_z, input string tag);
    logic [15:0] exp_dout;
    data_in = din;
    EN_MC   = en;
    start   = st;
    if (RST_N) exp_q.push_back(ref_shift(din, int'(model_total)));
    else       exp_q.push_back(16'h0000);
    @(posedge CLK);
    #1;
    checkOutput({tag, ".total"}, 32'(total), 32'(exp_total));
    checkOutput({tag, ".hold"}, 32'(hold), 32'(exp_hold));
    checkOutput({tag, ".z_flg"}, 32'(z_flg), 32'(exp_z));
    exp_dout = exp_q.pop_front();
    checkOutput({tag, ".data_out"}, {16'h0, data_out}, {16'h0, exp_dout});
    model_total = 5'(exp_total);
    start = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; data_in = 16'h7FFF; D_R_param = 8'd3; S_param = 5'd4;
    EN_MC = 1'b0; start = 1'b0; model_total = 5'd16;

    // Reset, idle, and a start pulse with the gate low (ignored)
    repeat (3) applyStimulus(16'h7FFF, 0, 0, 16, 0, 0, "reset");
    RST_N = 1'b1;
    applyStimulus(16'h7FFF, 0, 0, 16, 0, 0, "idle");
    applyStimulus(16'h7FFF, 0, 1, 16, 0, 0, "start_gate_low");

    // Decay cadence: D=3, S=4
    applyStimulus(16'h4000, 1, 1, 0, 0, 0, "decay_start");
    for (int m = 1; m <= 20; m++) begin
      et = (m / 4 > 4) ? 4 : m / 4;
      applyStimulus(16'h4000, 1, 0, et, et == 4, 0, "decay");
    end
    checkOutput("sustain_level", {16'h0, data_out}, 32'h0000_0400);

    // Release to silence, including negative full-scale input
    for (int m = 0; m <= 50; m++) begin
      et = (4 + m / 4 > 16) ? 16 : 4 + m / 4;
      applyStimulus((m >= 44) ? 16'h8000 : ((m % 2) != 0 ? 16'hC123 : 16'h7ABC),
                    0, 0, et, 0, et == 16, "release");
    end
    checkOutput("silence_neg", {16'h0, data_out}, 32'h0);
    applyStimulus(16'h1234, 0, 1, 16, 0, 1, "done_start_gate_low");

    // Retrigger from DONE, decay, release to total=9, retrigger mid-release
    applyStimulus(16'h4000, 1, 1, 0, 0, 0, "retrig_done");
    for (int m = 1; m <= 16; m++)
      applyStimulus(16'h4000, 1, 0, m / 4, m == 16, 0, "decay2");
    for (int m = 0; m <= 20; m++)
      applyStimulus(16'h4000, 0, 0, 4 + m / 4, 0, 0, "release2");
    applyStimulus(16'h2000, 1, 1, 0, 0, 0, "retrig_release");
    for (int m = 1; m <= 5; m++)
      applyStimulus(16'h2000, 1, 0, m / 4, 0, 0, "redecay");

    // Reset mid-operation
    RST_N = 1'b0;
    applyStimulus(16'h2000, 1, 0, 16, 0, 0, "mid_reset");
    RST_N = 1'b1;

    // S=0: sustain one edge after start, data_out is data_in delayed
    S_param = 5'd0;
    applyStimulus(16'h1111, 1, 1, 0, 0, 0, "s0_start");
    applyStimulus(16'h1234, 1, 0, 0, 1, 0, "s0_sustain");
    applyStimulus(16'h8001, 1, 0, 0, 1, 0, "s0_sustain");
    applyStimulus(16'h7FFF, 1, 0, 0, 1, 0, "s0_sustain");
    applyStimulus(16'hFFFF, 1, 0, 0, 1, 0, "s0_sustain");

    // D=0: release steps every cycle
    D_R_param = 8'd0;
    for (int m = 0; m <= 17; m++) begin
      et = (m > 16) ? 16 : m;
      applyStimulus(16'h7FFF, 0, 0, et, 0, et == 16, "fast_release");
    end

    // S=31 clamps to 16: silence while sustaining
    S_param = 5'd31;
    applyStimulus(16'h7FFF, 1, 1, 0, 0, 0, "s31_start");
    for (int m = 1; m <= 18; m++) begin
      et = (m > 16) ? 16 : m;
      applyStimulus(16'h8000, 1, 0, et, m >= 16, 0, "s31");
    end
    checkOutput("s31_silence", {16'h0, data_out}, 32'h0);

    // Retrigger out of SUSTAIN into S=2, then rounding checks at total=2
    S_param = 5'd2;
    applyStimulus(16'hFFFD, 1, 1, 0, 0, 0, "retrig_sustain");
    applyStimulus(16'hFFFD, 1, 0, 1, 0, 0, "s2_decay");
    applyStimulus(16'hFFFD, 1, 0, 2, 1, 0, "s2_decay");
    applyStimulus(16'hFFFD, 1, 0, 2, 1, 0, "round_neg");
    checkOutput("round_neg_val", {16'h0, data_out}, 32'h0000_FFFF);
    applyStimulus(16'h0006, 1, 0, 2, 1, 0, "round_pos");
`ifdef ENV_ROUND_EN
    checkOutput("round_pos_val", {16'h0, data_out}, 32'h0000_0002);
`else
    checkOutput("round_pos_val", {16'h0, data_out}, 32'h0000_0001);
`endif

    // Gate drops during DECAY: release continues from the current total
    S_param = 5'd4; D_R_param = 8'd1;
    applyStimulus(16'h4000, 1, 1, 0, 0, 0, "dg_start");
    applyStimulus(16'h4000, 1, 0, 0, 0, 0, "dg_decay");
    applyStimulus(16'h4000, 1, 0, 1, 0, 0, "dg_decay");
    applyStimulus(16'h4000, 0, 0, 1, 0, 0, "decay_gate_low");
    applyStimulus(16'h4000, 0, 0, 1, 0, 0, "dg_release");
    applyStimulus(16'h4000, 0, 0, 2, 0, 0, "dg_release");
    applyStimulus(16'h4000, 0, 0, 2, 0, 0, "dg_release");
    applyStimulus(16'h4000, 0, 0, 3, 0, 0, "dg_release");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
